// File: rtl/cam_timing_gen.sv
// OV7670-style camera transmitter: pclk = clk/2 with VSYNC/HREF/D[7:0] frame timing.
// Optional `CAMGEN_COLORBAR_EN: RGB565 colour bars on d instead of the default byte ramp.
module cam_timing_gen #(
    parameter int unsigned H_BLANK  = 288,
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned V_TOTAL  = 510,
    parameter int unsigned V_SYNC   = 3,
    parameter int unsigned V_START  = 20,
    parameter int unsigned V_ACTIVE = 480
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       single,
    output logic       pclk,
    output logic       vsync,
    output logic       href,
    output logic [7:0] d,
    output logic       frame_done,
    output logic       busy
);
    localparam int unsigned H_TOTAL = H_BLANK + H_ACTIVE;
    localparam int unsigned HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int unsigned VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic          ph_q, ph_d;
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic          vsync_q, vsync_d;
    logic          href_q, href_d;
    logic [7:0]    d_q, d_d;
    logic          done_q, done_d;
    logic          line_end, frame_end;
    logic [HW-1:0] b;
    logic [7:0]    pix;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ph_q    <= 1'b0;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            d_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            vsync_q <= vsync_d;
            href_q  <= href_d;
            d_q     <= d_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        line_end  = (h_cnt_q == HW'(H_TOTAL - 1));
        frame_end = line_end && (v_cnt_q == VW'(V_TOTAL - 1));
    end

    // Counters only move on the clk where pclk falls (ph 1->0).
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                ph_d    = 1'b0;
                h_cnt_d = '0;
                v_cnt_d = '0;
                if (en) state_d = RUN;
            end
            RUN: begin
                ph_d = ~ph_q;
                if (ph_q) begin
                    if (line_end) begin
                        h_cnt_d = '0;
                        if (frame_end) begin
                            v_cnt_d = '0;
                            done_d  = 1'b1;
                            if (!en || single) state_d = IDLE;
                        end else begin
                            v_cnt_d = v_cnt_q + VW'(1);
                        end
                    end else begin
                        h_cnt_d = h_cnt_q + HW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef CAMGEN_COLORBAR_EN
    logic [31:0] bar_idx;
    logic [2:0]  bar;
    logic [15:0] rgb;

    always_comb begin
        bar_idx = 32'(b) >> 8;
        bar     = (bar_idx > 32'd7) ? 3'd7 : 3'(bar_idx);
        case (bar)
            3'd0:    rgb = 16'hFFFF;
            3'd1:    rgb = 16'hFFE0;
            3'd2:    rgb = 16'h07FF;
            3'd3:    rgb = 16'h07E0;
            3'd4:    rgb = 16'hF81F;
            3'd5:    rgb = 16'hF800;
            3'd6:    rgb = 16'h001F;
            default: rgb = 16'h0000;
        endcase
        pix = b[0] ? rgb[7:0] : rgb[15:8];
    end
`else
    always_comb begin
        pix = 8'(b) ^ 8'(v_cnt_d);
    end
`endif

    // Outputs are decoded from next-state counters so they register together with them.
    always_comb begin
        b       = h_cnt_d - HW'(H_BLANK);
        vsync_d = 1'b0;
        href_d  = 1'b0;
        d_d     = '0;
        if (state_d == RUN) begin
            vsync_d = (32'(v_cnt_d) < V_SYNC);
            href_d  = (32'(h_cnt_d) >= H_BLANK) && (32'(v_cnt_d) >= V_START)
                      && (32'(v_cnt_d) < V_START + V_ACTIVE);
            if (href_d) d_d = pix;
        end
    end

    assign pclk       = ph_q;
    assign vsync      = vsync_q;
    assign href       = href_q;
    assign d          = d_q;
    assign frame_done = done_q;
    assign busy       = (state_q == RUN);

endmodule

// File: tb/tb_cam_timing_gen.sv
// Self-checking bench for cam_timing_gen with small frame parameters and randomized en/single.
// The reference model tracks elapsed clks since frame start and derives outputs arithmetically.
module tb_cam_timing_gen;
    localparam int unsigned HB = 4, HA = 8, VT = 6, VS = 1, VST = 2, VA = 3;
    localparam int unsigned HT = HB + HA;
    localparam int unsigned FR = HT * VT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       single = 1'b0;
    logic       pclk, vsync, href, frame_done, busy;
    logic [7:0] d;
    logic [12:0] obs_v;

    int checks = 0;
    int errors = 0;

    bit          m_run = 1'b0;
    int unsigned m_n = 0;
    logic [12:0] m_exp = '0;

    cam_timing_gen #(
        .H_BLANK(HB), .H_ACTIVE(HA), .V_TOTAL(VT),
        .V_SYNC(VS), .V_START(VST), .V_ACTIVE(VA)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .single(single),
        .pclk(pclk), .vsync(vsync), .href(href), .d(d),
        .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    always_comb obs_v = {pclk, vsync, href, d, frame_done, busy};

`ifdef CAMGEN_COLORBAR_EN
    localparam logic [15:0] COLS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                        16'hF81F, 16'hF800, 16'h001F, 16'h0000};
`endif

    // Expected {pclk,vsync,href,d,frame_done,busy} n clks after the frame's start edge.
    function automatic logic [12:0] exp_run(int unsigned n);
        int unsigned p, h, v, b, bar;
        logic vs, hr;
        logic [7:0] dd;
        p  = n / 2;
        h  = p % HT;
        v  = p / HT;
        vs = (v < VS);
        hr = (h >= HB) && (v >= VST) && (v < VST + VA);
        dd = 8'h00;
        bar = 0;
        if (hr) begin
            b = h - HB;
`ifdef CAMGEN_COLORBAR_EN
            bar = (b / 256 > 7) ? 7 : b / 256;
            dd  = (b % 2 == 1) ? COLS[bar][7:0] : COLS[bar][15:8];
`else
            dd  = 8'((b ^ v) % 256);
`endif
        end
        return {1'(n % 2), vs, hr, dd, 1'b0, 1'b1};
    endfunction

    function automatic void model_edge(bit e, bit s);
        bit fd;
        fd = 1'b0;
        if (!m_run) begin
            if (e) begin
                m_run = 1'b1;
                m_n   = 0;
            end
        end else begin
            m_n++;
            if (m_n == 2 * FR) begin
                fd = 1'b1;
                if (e && !s) m_n = 0;
                else m_run = 1'b0;
            end
        end
        m_exp    = m_run ? exp_run(m_n) : 13'h0;
        m_exp[1] = fd;
    endfunction

    task automatic step();
        model_edge(en, single);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; single = 1'b0;
        m_run = 1'b0; m_n = 0;
        @(posedge clk);
        #1;
        checks++;
        if (obs_v !== 13'h0) begin
            errors++;
            $display("FAIL reset_values: got %h expected %h", obs_v, 13'h0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (obs_v !== m_exp) begin
                errors++;
                $display("FAIL idle_hold: got %h expected %h", obs_v, m_exp);
            end
        end
    endtask

    task automatic test_single_frame();
        logic [7:0] q[$];
        logic [7:0] exp_l2 [8];
        int dones, vs_cnt;
        exp_l2 = '{8'h02, 8'h03, 8'h00, 8'h01, 8'h06, 8'h07, 8'h04, 8'h05};
        dones = 0; vs_cnt = 0;
        single = 1'b1; en = 1'b1;
        for (int i = 1; i <= 2 * FR + 4; i++) begin
            step();
            checks++;
            if (obs_v !== m_exp) begin
                errors++;
                $display("FAIL single_frame step %0d: got %h expected %h", i, obs_v, m_exp);
            end
            if (frame_done) dones++;
            if (pclk && vsync) vs_cnt++;
            if (pclk && href) q.push_back(d);
            en = (i <= 2 * FR) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL single_done_count: got %0d expected 1", dones);
        end
        checks++;
        if (vs_cnt != VS * HT) begin
            errors++;
            $display("FAIL vsync_pclks: got %0d expected %0d", vs_cnt, VS * HT);
        end
        checks++;
        if (q.size() != VA * HA) begin
            errors++;
            $display("FAIL href_bytes: got %0d expected %0d", q.size(), VA * HA);
        end
`ifndef CAMGEN_COLORBAR_EN
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (q.size() <= k || q[k] !== exp_l2[k]) begin
                errors++;
                $display("FAIL line2_byte%0d: got %h expected %h", k,
                         (q.size() > k) ? q[k] : 8'hxx, exp_l2[k]);
            end
        end
        checks++;
        if (q.size() <= 8 || q[8] !== 8'h03) begin
            errors++;
            $display("FAIL line3_first: got %h expected 03", (q.size() > 8) ? q[8] : 8'hxx);
        end
`endif
    endtask

    task automatic test_en_drop();
        int dones;
        dones = 0;
        single = 1'b0; en = 1'b1;
        for (int i = 1; i <= 6 * FR; i++) begin
            step();
            checks++;
            if (obs_v !== m_exp) begin
                errors++;
                $display("FAIL en_drop step %0d: got %h expected %h", i, obs_v, m_exp);
            end
            if (frame_done) dones++;
            if (i < 2 * FR) en = 1'($urandom_range(0, 1));
            else if (i < 3 * FR) en = 1'b1;
            else en = 1'b0;
        end
        checks++;
        if (dones != 2) begin
            errors++;
            $display("FAIL en_drop_done_count: got %0d expected 2", dones);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL en_drop_idle: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        single = 1'b0; en = 1'b1;
        for (int i = 0; i < 2 * 3 * HT + 6; i++) begin
            step();
            checks++;
            if (obs_v !== m_exp) begin
                errors++;
                $display("FAIL pre_reset step %0d: got %h expected %h", i, obs_v, m_exp);
            end
        end
        #2 rst_n = 1'b0;
        m_run = 1'b0; m_n = 0;
        #1;
        checks++;
        if (obs_v !== 13'h0) begin
            errors++;
            $display("FAIL reset_mid_async: got %h expected %h", obs_v, 13'h0);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (obs_v !== 13'h0) begin
                errors++;
                $display("FAIL reset_hold: got %h expected %h", obs_v, 13'h0);
            end
        end
        rst_n = 1'b1; en = 1'b1; single = 1'b1;
        for (int i = 0; i < 2 * FR + 3; i++) begin
            step();
            checks++;
            if (obs_v !== m_exp) begin
                errors++;
                $display("FAIL restart step %0d: got %h expected %h", i, obs_v, m_exp);
            end
            if (i == 0 && (vsync !== 1'b1 || pclk !== 1'b0)) begin
                errors++;
                $display("FAIL restart_vsync: got vsync=%b pclk=%b expected vsync=1 pclk=0", vsync, pclk);
            end
            en = 1'b0;
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 3 * FR + int'($urandom_range(0, 40)); i++) begin
                en     = ($urandom_range(0, 3) != 0);
                single = ($urandom_range(0, 5) == 0);
                step();
                checks++;
                if (obs_v !== m_exp) begin
                    errors++;
                    $display("FAIL random run %0d step %0d: got %h expected %h", r, i, obs_v, m_exp);
                end
            end
        end
        en = 1'b0;
        for (int i = 0; i < 2 * FR + 2; i++) begin
            step();
            checks++;
            if (obs_v !== m_exp) begin
                errors++;
                $display("FAIL random_drain step %0d: got %h expected %h", i, obs_v, m_exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_en_drop();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
